mem_seq: RTL and testbench
==========================

MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set address width.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum WAIT cycles before abort (1..255).
REQ-003 clk  in  1  single clock; all state SHALL change on posedge clk.
REQ-004 nrst  in  1  asynchronous, active-low reset.
REQ-005 f_req  in  1  instruction-fetch request; held high until f_done.
REQ-006 f_addr  in  ADDR_W  fetch address.
REQ-007 d_req  in  1  data-access request; held high until d_done.
REQ-008 d_we  in  1  data access is a write (1) or read (0).
REQ-009 d_addr  in  ADDR_W  data address.
REQ-010 f_gnt, d_gnt  out  1  one-cycle grant pulse per requester.
REQ-011 f_done, d_done  out  1  one-cycle completion pulse per requester.
REQ-012 mem_addr  out  ADDR_W  latched transaction address.
REQ-013 mem_rd, mem_wr  out  1  memory read/write strobes.
REQ-014 mem_ack  in  1  memory completion, sampled in WAIT only.
REQ-015 mar_load  out  1  address-register load strobe.
REQ-016 mdr_load  out  1  MDR capture strobe (MDR loads mem_bus on the edge ending this cycle).
REQ-017 mdr_valid  out  1  MDR bus-drive enable.
REQ-018 err  out  1  timeout indication, pulsed with the done of the aborted transaction.

Function
REQ-019 FSM states SHALL be IDLE, ADDR, WAIT, LOAD, DONE.
REQ-020 IDLE: with any request pending, the FSM SHALL go to ADDR next cycle, pulse the winner's gnt in that same IDLE cycle, and latch address, requester ID and op (fetch = read).
REQ-021 Arbitration SHALL be round-robin: on simultaneous requests the requester not served last wins; a lone request wins immediately.
REQ-022 ADDR: mar_load=1 for exactly one cycle, mem_addr valid; next state WAIT.
REQ-023 WAIT: mem_rd (read) or mem_wr (write) SHALL be held high, and mdr_valid=1 throughout WAIT for writes.
REQ-024 WAIT exit on mem_ack=1: read goes to LOAD, write goes to DONE; strobes drop in the following state.
REQ-025 A WAIT cycle counter SHALL clear on WAIT entry; after TIMEOUT WAIT cycles with no ack, the FSM SHALL go to DONE with an error flag set.
REQ-026 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-027 LOAD: mdr_load=1 for one cycle; next state DONE.
REQ-028 DONE: pulse the served requester's done for one cycle, with mdr_valid=1 for successful reads and err=1 if aborted; next state IDLE.
REQ-029 Minimum latency SHALL be: grant at cycle 0, done at cycle 4 for a read with ack on the first WAIT cycle, and cycle 3 for a write.
REQ-030 Requests deasserting after grant SHALL NOT cancel the transaction, and requests SHALL NOT be re-evaluated outside IDLE.
REQ-031 A request still high in the DONE cycle SHALL NOT be granted again until the next IDLE cycle.
REQ-032 mem_ack outside WAIT SHALL be ignored.
REQ-033 All strobe outputs SHALL be registered and glitch-free, and at most one of mar_load/mdr_load/mem_rd/mem_wr may be high per cycle, except that mdr_valid may accompany mem_wr.

Reset
REQ-034 nrst=0 SHALL immediately force state IDLE, all outputs 0, mem_addr 0, counter 0, and the round-robin pointer to "data served last" so fetch wins the first tie.
REQ-035 Reset mid-transaction SHALL abandon the transaction with no done pulse, and a new transaction SHALL start only after reset deassertion.

Structure
REQ-036 The state encoding, requester IDs and the TIMEOUT default SHALL live in the shared processor definitions package/include alongside the OP/ADDR widths.
REQ-037 The round-robin arbiter SHALL be a sub-module, rr_arb2 (two requests in, grant vector out, last-served pointer).

Verification
REQ-038 f_req only, addr 0x3C, ack on 2nd WAIT cycle -> f_gnt at cycle 0, mar_load at cycle 1, mem_rd at cycles 2-3, mdr_load at cycle 4, f_done+mdr_valid at cycle 5, mem_addr=0x3C.
REQ-039 d_req write addr 0x80, ack on 1st WAIT cycle -> mem_wr+mdr_valid at cycle 2, d_done at cycle 3, no mdr_load.
REQ-040 f_req and d_req held high continuously after reset -> grants alternate f,d,f,d across 4 transactions.
REQ-041 Read with mem_ack never asserted, TIMEOUT=15 -> mem_rd high exactly 15 cycles, then done+err together, no mdr_load, FSM back in IDLE.
REQ-042 nrst pulsed low during WAIT -> outputs 0 in the same cycle, no done pulse, and a fresh request after release is served normally.
REQ-043 mem_ack pulsed while in IDLE, followed by a read -> stray ack ignored, and the read completes only on its own ack.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory sequencer: widths, timeout default,
// FSM state encoding, requester IDs and the latched transaction record.
package mem_seq_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int OP_W        = 1;
    localparam int TIMEOUT_DEF = 15;
    localparam int CNT_W       = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        LOAD = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    typedef enum logic [OP_W-1:0] {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    typedef struct packed {
        req_id_t id;
        op_t     op;
    } txn_t;

    function automatic logic is_read(input txn_t t);
        return t.op == OP_READ;
    endfunction

endpackage

// File: rtl/mem_seq_if.sv
// Requester and memory-side signal bundle of the sequencer; the sequencer
// itself connects through the slave modport.
interface mem_seq_if
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic              f_gnt;
    logic              d_gnt;
    logic              f_done;
    logic              d_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_ack;
    logic              mar_load;
    logic              mdr_load;
    logic              mdr_valid;
    logic              err;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, mem_ack,
        output f_gnt, d_gnt, f_done, d_done, mem_addr,
               mem_rd, mem_wr, mar_load, mdr_load, mdr_valid, err
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, mem_ack,
        input  f_gnt, d_gnt, f_done, d_done, mem_addr,
               mem_rd, mem_wr, mar_load, mdr_load, mdr_valid, err
    );

endinterface

// File: rtl/mem_seq_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 is fetch, bit 1 is data; on a tie
// the requester not served last wins.
module rr_arb2
    import mem_seq_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    req_id_t    r_last;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        case (i_req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = (r_last == REQ_DATA) ? 2'b01 : 2'b10;
            default: w_gnt = 2'b00;
        endcase
    end

    assign o_gnt = w_gnt;

    // Resetting to "data served last" makes fetch win the first tie.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_last <= REQ_DATA;
        end else if (i_update && (w_gnt != 2'b00)) begin
            r_last <= w_gnt[1] ? REQ_DATA : REQ_FETCH;
        end
    end

endmodule

// File: rtl/mem_seq.sv
// Memory access sequencer: arbitrates fetch/data requesters and walks a
// single memory transaction through IDLE/ADDR/WAIT/LOAD/DONE.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic     clk,
    input  logic     nrst,
    mem_seq_if.slave bus
);

    state_t            r_state;
    txn_t              r_txn;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mar_load;
    logic              r_mdr_load;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic              r_mdr_valid;
    logic              r_f_done;
    logic              r_d_done;
    logic              r_err;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_idle;

    assign w_req  = {bus.d_req, bus.f_req};
    assign w_idle = (r_state == IDLE);

    rr_arb2 u_arb (
        .clk      (clk),
        .nrst     (nrst),
        .i_req    (w_req),
        .i_update (w_idle),
        .o_gnt    (w_gnt)
    );

    // Grants are only meaningful in IDLE and must stay low while in reset.
    assign bus.f_gnt     = w_gnt[0] & w_idle & nrst;
    assign bus.d_gnt     = w_gnt[1] & w_idle & nrst;
    assign bus.f_done    = r_f_done;
    assign bus.d_done    = r_d_done;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mar_load  = r_mar_load;
    assign bus.mdr_load  = r_mdr_load;
    assign bus.mdr_valid = r_mdr_valid;
    assign bus.err       = r_err;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_txn       <= '{id: REQ_FETCH, op: OP_READ};
            r_addr      <= '0;
            r_cnt       <= '0;
            r_mar_load  <= 1'b0;
            r_mdr_load  <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mdr_valid <= 1'b0;
            r_f_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mar_load  <= 1'b0;
            r_mdr_load  <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mdr_valid <= 1'b0;
            r_f_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_err       <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_txn.id   <= w_gnt[1] ? REQ_DATA : REQ_FETCH;
                        r_txn.op   <= (w_gnt[1] && bus.d_we) ? OP_WRITE : OP_READ;
                        r_addr     <= w_gnt[1] ? bus.d_addr : bus.f_addr;
                        r_mar_load <= 1'b1;
                        r_state    <= ADDR;
                    end
                end

                ADDR: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                    if (is_read(r_txn)) begin
                        r_mem_rd <= 1'b1;
                    end else begin
                        r_mem_wr    <= 1'b1;
                        r_mdr_valid <= 1'b1;
                    end
                end

                // An ack in the final allowed cycle still wins over the timeout.
                WAIT: begin
                    if (bus.mem_ack) begin
                        if (is_read(r_txn)) begin
                            r_mdr_load <= 1'b1;
                            r_state    <= LOAD;
                        end else begin
                            r_f_done <= (r_txn.id == REQ_FETCH);
                            r_d_done <= (r_txn.id == REQ_DATA);
                            r_state  <= DONE;
                        end
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_f_done <= (r_txn.id == REQ_FETCH);
                        r_d_done <= (r_txn.id == REQ_DATA);
                        r_err    <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (is_read(r_txn)) begin
                            r_mem_rd <= 1'b1;
                        end else begin
                            r_mem_wr    <= 1'b1;
                            r_mdr_valid <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    r_f_done    <= (r_txn.id == REQ_FETCH);
                    r_d_done    <= (r_txn.id == REQ_DATA);
                    r_mdr_valid <= 1'b1;
                    r_state     <= DONE;
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq: each step drives one cycle of inputs and
// compares the packed output strobes against hand-derived values.
module tb_mem_seq;

    logic clk;
    logic nrst;
    int   vecs  = 0;
    int   fails = 0;

    mem_seq_if #(.ADDR_W(8)) bus ();

    mem_seq #(.ADDR_W(8), .TIMEOUT(15)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: f_gnt d_gnt f_done d_done mar_load mem_rd mem_wr mdr_load mdr_valid err
    function automatic logic [9:0] outVec();
        return {bus.f_gnt, bus.d_gnt, bus.f_done, bus.d_done, bus.mar_load,
                bus.mem_rd, bus.mem_wr, bus.mdr_load, bus.mdr_valid, bus.err};
    endfunction

    task automatic applyStimulus(input logic rn, input logic fr, input logic [7:0] fa,
                                 input logic dr, input logic dw, input logic [7:0] da,
                                 input logic ack);
        @(posedge clk);
        #1;
        nrst        = rn;
        bus.f_req   = fr;
        bus.f_addr  = fa;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.mem_ack = ack;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkVec(input string tag, input logic [9:0] exp);
        checkOutput(tag, 32'(outVec()), 32'(exp));
    endtask

    logic [9:0] expG;
    logic [9:0] expD;
    logic [7:0] expA;

    initial begin
        nrst        = 1'b0;
        bus.f_req   = 1'b1;
        bus.f_addr  = 8'h3C;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 8'h00;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkVec("rst_outs", 10'b0000000000);
        checkOutput("rst_addr", 32'(bus.mem_addr), 32'h0);

        $display("[TB] fetch read 0x3C, ack on 2nd WAIT cycle");
        applyStimulus(1, 1, 8'h3C, 0, 0, 8'h00, 0);
        checkVec("rd_c0_gnt", 10'b1000000000);
        applyStimulus(1, 1, 8'h3C, 0, 0, 8'h00, 0);
        checkVec("rd_c1_mar", 10'b0000100000);
        checkOutput("rd_addr", 32'(bus.mem_addr), 32'h3C);
        applyStimulus(1, 1, 8'h3C, 0, 0, 8'h00, 0);
        checkVec("rd_c2_rd", 10'b0000010000);
        applyStimulus(1, 1, 8'h3C, 0, 0, 8'h00, 1);
        checkVec("rd_c3_rd", 10'b0000010000);
        applyStimulus(1, 1, 8'h3C, 0, 0, 8'h00, 0);
        checkVec("rd_c4_mdrld", 10'b0000000100);
        applyStimulus(1, 1, 8'h3C, 0, 0, 8'h00, 0);
        checkVec("rd_c5_done", 10'b0010000010);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0);
        checkVec("rd_c6_idle", 10'b0000000000);

        $display("[TB] data write 0x80, ack on 1st WAIT cycle");
        applyStimulus(1, 0, 8'h00, 1, 1, 8'h80, 0);
        checkVec("wr_c0_gnt", 10'b0100000000);
        applyStimulus(1, 0, 8'h00, 1, 1, 8'h80, 0);
        checkVec("wr_c1_mar", 10'b0000100000);
        checkOutput("wr_addr", 32'(bus.mem_addr), 32'h80);
        applyStimulus(1, 0, 8'h00, 1, 1, 8'h80, 1);
        checkVec("wr_c2_wr", 10'b0000001010);
        applyStimulus(1, 0, 8'h00, 1, 1, 8'h80, 0);
        checkVec("wr_c3_done", 10'b0001000000);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0);
        checkVec("wr_c4_idle", 10'b0000000000);

        $display("[TB] both requesters held high");
        for (int t = 0; t < 4; t++) begin
            expG = (t % 2 == 1) ? 10'b0100000000 : 10'b1000000000;
            expD = (t % 2 == 1) ? 10'b0001000010 : 10'b0010000010;
            expA = (t % 2 == 1) ? 8'h22 : 8'h11;
            applyStimulus(1, 1, 8'h11, 1, 0, 8'h22, 0);
            checkVec($sformatf("rr%0d_gnt", t), expG);
            applyStimulus(1, 1, 8'h11, 1, 0, 8'h22, 0);
            checkOutput($sformatf("rr%0d_addr", t), 32'(bus.mem_addr), 32'(expA));
            applyStimulus(1, 1, 8'h11, 1, 0, 8'h22, 1);
            checkVec($sformatf("rr%0d_rd", t), 10'b0000010000);
            applyStimulus(1, 1, 8'h11, 1, 0, 8'h22, 0);
            checkVec($sformatf("rr%0d_mdrld", t), 10'b0000000100);
            applyStimulus(1, 1, 8'h11, 1, 0, 8'h22, 0);
            checkVec($sformatf("rr%0d_done", t), expD);
        end
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0);
        checkVec("rr_idle", 10'b0000000000);

        $display("[TB] read timeout with no ack");
        applyStimulus(1, 1, 8'h55, 0, 0, 8'h00, 0);
        checkVec("to_gnt", 10'b1000000000);
        applyStimulus(1, 1, 8'h55, 0, 0, 8'h00, 0);
        checkVec("to_mar", 10'b0000100000);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1, 1, 8'h55, 0, 0, 8'h00, 0);
            checkVec($sformatf("to_wait%0d", k), 10'b0000010000);
        end
        applyStimulus(1, 1, 8'h55, 0, 0, 8'h00, 0);
        checkVec("to_done_err", 10'b0010000001);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0);
        checkVec("to_idle", 10'b0000000000);

        $display("[TB] ack on the last allowed WAIT cycle");
        applyStimulus(1, 1, 8'h66, 0, 0, 8'h00, 0);
        checkVec("lt_gnt", 10'b1000000000);
        applyStimulus(1, 1, 8'h66, 0, 0, 8'h00, 0);
        for (int k = 0; k < 14; k++) begin
            applyStimulus(1, 1, 8'h66, 0, 0, 8'h00, 0);
        end
        applyStimulus(1, 1, 8'h66, 0, 0, 8'h00, 1);
        checkVec("lt_wait15", 10'b0000010000);
        applyStimulus(1, 1, 8'h66, 0, 0, 8'h00, 0);
        checkVec("lt_mdrld", 10'b0000000100);
        applyStimulus(1, 1, 8'h66, 0, 0, 8'h00, 0);
        checkVec("lt_done_ok", 10'b0010000010);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0);

        $display("[TB] reset during WAIT");
        applyStimulus(1, 0, 8'h00, 1, 0, 8'h44, 0);
        checkVec("rw_gnt", 10'b0100000000);
        applyStimulus(1, 0, 8'h00, 1, 0, 8'h44, 0);
        applyStimulus(1, 0, 8'h00, 1, 0, 8'h44, 0);
        checkVec("rw_wait", 10'b0000010000);
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h44, 1);
        checkVec("rw_in_rst", 10'b0000000000);
        checkOutput("rw_addr0", 32'(bus.mem_addr), 32'h0);
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h44, 0);
        checkVec("rw_in_rst2", 10'b0000000000);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0);
        checkVec("rw_no_done", 10'b0000000000);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0);
        checkVec("rw_no_done2", 10'b0000000000);
        applyStimulus(1, 0, 8'h00, 1, 0, 8'h9A, 0);
        checkVec("rw_new_gnt", 10'b0100000000);
        applyStimulus(1, 0, 8'h00, 1, 0, 8'h9A, 0);
        checkOutput("rw_new_addr", 32'(bus.mem_addr), 32'h9A);
        applyStimulus(1, 0, 8'h00, 1, 0, 8'h9A, 1);
        applyStimulus(1, 0, 8'h00, 1, 0, 8'h9A, 0);
        checkVec("rw_new_mdrld", 10'b0000000100);
        applyStimulus(1, 0, 8'h00, 1, 0, 8'h9A, 0);
        checkVec("rw_new_done", 10'b0001000010);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0);

        $display("[TB] stray ack outside WAIT");
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 1);
        checkVec("sa_idle_ack", 10'b0000000000);
        applyStimulus(1, 1, 8'h77, 0, 0, 8'h00, 0);
        checkVec("sa_gnt", 10'b1000000000);
        applyStimulus(1, 1, 8'h77, 0, 0, 8'h00, 1);
        checkVec("sa_mar_ack", 10'b0000100000);
        applyStimulus(1, 1, 8'h77, 0, 0, 8'h00, 0);
        checkVec("sa_wait1", 10'b0000010000);
        applyStimulus(1, 1, 8'h77, 0, 0, 8'h00, 0);
        checkVec("sa_wait2", 10'b0000010000);
        applyStimulus(1, 1, 8'h77, 0, 0, 8'h00, 1);
        checkVec("sa_wait3", 10'b0000010000);
        applyStimulus(1, 1, 8'h77, 0, 0, 8'h00, 0);
        checkVec("sa_mdrld", 10'b0000000100);
        applyStimulus(1, 1, 8'h77, 0, 0, 8'h00, 0);
        checkVec("sa_done", 10'b0010000010);
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0);
        checkVec("sa_idle", 10'b0000000000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
